bus_receiver: RTL and testbench
===============================

BUS_RECEIVER -- requirements
Module: bus_receiver

Interface
REQ-001 Parameter MY_ADDR, default 4'd1, node address this receiver accepts.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 bus_in  input  1  serial shared-bus line, one bit per clock; idle level 0.
REQ-005 rx_data  output  64  payload of last accepted frame.
REQ-006 rx_valid  output  1  one-cycle pulse: new payload on rx_data.
REQ-007 crc_err  output  1  one-cycle pulse: addressed frame failed CRC.
REQ-008 busy  output  1  high while a frame is being received (FSM not IDLE).
REQ-009 frame_cnt  output  8  count of accepted frames, saturating at 8'hFF.
REQ-010 err_cnt  output  8  count of CRC-failed addressed frames, saturating at 8'hFF.

Function
REQ-011 Frame format SHALL be: start bit (1), addr[3:0], data[63:0], crc[3:0]; MSB first; one bit per clock; 73 bits total.
REQ-012 FSM SHALL have states IDLE, ADDR, DATA, CRC.
REQ-013 IDLE -> ADDR when bus_in=1 is sampled; bus_in=0 keeps IDLE.
REQ-014 ADDR SHALL last exactly 4 cycles, then DATA; DATA exactly 64 cycles, then CRC; CRC exactly 4 cycles, then IDLE. The bit counter is 7 bits and SHALL reset to 0 on each state entry.
REQ-015 Bus value SHALL be ignored as a start/abort indicator inside a frame; there is no mid-frame resynchronisation.
REQ-016 CRC-4 SHALL use polynomial x^4+x+1 over the 68 addr+data bits: reg c init 4'h0 at start bit; per bit b: fb=c[3]^b, c<={c[2],c[1],c[0]^fb,fb}.
REQ-017 Received crc[3:0] SHALL be compared to c after the last data bit.
REQ-018 Edge that samples the last CRC bit: if addr==MY_ADDR and CRC matches, rx_data<=data, rx_valid<=1, frame_cnt increments.
REQ-019 Same edge: if addr==MY_ADDR and CRC mismatches, crc_err<=1, err_cnt increments, rx_data unchanged.
REQ-020 If addr!=MY_ADDR, the frame SHALL be consumed to its end with no pulse, no counter change, rx_data unchanged.
REQ-021 Latency: start bit sampled at edge N, rx_valid/crc_err high during the cycle after edge N+72, for exactly one cycle.
REQ-022 FSM SHALL be in IDLE in the cycle where rx_valid or crc_err is high, so a start bit on that cycle begins the next frame (back-to-back, zero gap).
REQ-023 busy SHALL be high from the cycle after the start bit through the cycle in which the last CRC bit is on bus_in.
REQ-024 Counters SHALL hold at 8'hFF; no wrap to 0.
REQ-025 rx_valid and crc_err SHALL never be high together.

Reset
REQ-026 When reset_n=0 at an edge: FSM<=IDLE, bit counter, CRC reg and shift reg <=0, rx_data<=64'h0, rx_valid<=0, crc_err<=0, frame_cnt<=0, err_cnt<=0; busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no pulse; after release, the first sampled bus_in=1 starts a new frame.
REQ-028 Reset SHALL take priority over all other events at the same edge.

Verification
REQ-029 MY_ADDR=1; frame addr=4'h1, data=64'h1, crc=4'h6 -> rx_valid one pulse 73 cycles after start bit, rx_data=64'h1, frame_cnt=1, err_cnt=0.
REQ-030 Same frame with crc=4'h7 -> crc_err one pulse, rx_valid=0, rx_data unchanged, err_cnt=1.
REQ-031 Frame addr=4'h2, data=64'h1, any crc -> no rx_valid, no crc_err, counters unchanged, busy high for 72 cycles then 0.
REQ-032 Two valid frames back-to-back, second start bit on the rx_valid cycle -> two rx_valid pulses exactly 73 cycles apart, frame_cnt=2.
REQ-033 reset_n=0 for 1 cycle at bit 30 of a frame, then a full valid frame -> no pulse for the aborted frame, one rx_valid for the new frame, frame_cnt=1.
REQ-034 256 valid frames -> frame_cnt=8'hFF after frame 255 and stays 8'hFF after frame 256.

Source files
------------

// File: rtl/bus_receiver_if.sv
// Serial shared-bus receiver signal bundle: the bus line in, frame results and statistics out.
interface bus_receiver_if;
    logic        bus_in;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        crc_err;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;

    modport slave (
        input  bus_in,
        output rx_data, rx_valid, crc_err, busy, frame_cnt, err_cnt
    );

    modport master (
        output bus_in,
        input  rx_data, rx_valid, crc_err, busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/bus_receiver.sv
// Serial frame receiver: start bit, 4-bit address, 64-bit payload, CRC-4 (x^4+x+1), MSB first.
// Frames for MY_ADDR are checked and either delivered (rx_valid) or flagged (crc_err).
module bus_receiver #(
    parameter logic [3:0] MY_ADDR = 4'd1
) (
    input  logic          clock,
    input  logic          reset_n,
    bus_receiver_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CRC} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [6:0]  r_bit_cnt;
    logic [3:0]  r_addr;
    logic [63:0] r_shift;
    logic [3:0]  r_crc;
    logic [2:0]  r_crc_rx;
    logic [63:0] r_rx_data;
    logic        r_rx_valid;
    logic        r_crc_err;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_err_cnt;

    logic        w_busy;
    logic        w_frame_end;
    logic        w_addr_match;
    logic        w_crc_ok;
    logic        w_crc_fb;
    logic [3:0]  w_crc_next;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the bus is only a start indicator while idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.bus_in)            w_state_next = S_ADDR;
            S_ADDR: if (r_bit_cnt == 7'd3)     w_state_next = S_DATA;
            S_DATA: if (r_bit_cnt == 7'd63)    w_state_next = S_CRC;
            S_CRC:  if (r_bit_cnt == 7'd3)     w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    // Output / decode logic; the last CRC bit is taken straight from the bus
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_frame_end  = (r_state == S_CRC) && (r_bit_cnt == 7'd3);
        w_addr_match = (r_addr == MY_ADDR);
        w_crc_ok     = ({r_crc_rx, bus.bus_in} == r_crc);
        w_crc_fb     = r_crc[3] ^ bus.bus_in;
        w_crc_next   = {r_crc[2], r_crc[1], r_crc[0] ^ w_crc_fb, w_crc_fb};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_bit_cnt   <= 7'd0;
            r_addr      <= 4'h0;
            r_shift     <= 64'h0;
            r_crc       <= 4'h0;
            r_crc_rx    <= 3'h0;
            r_rx_data   <= 64'h0;
            r_rx_valid  <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_cnt <= 8'h00;
            r_err_cnt   <= 8'h00;
        end else begin
            r_rx_valid <= 1'b0;
            r_crc_err  <= 1'b0;

            if (w_state_next != r_state) begin
                r_bit_cnt <= 7'd0;
            end else if (r_state != S_IDLE) begin
                r_bit_cnt <= r_bit_cnt + 7'd1;
            end

            case (r_state)
                S_IDLE: r_crc <= 4'h0;
                S_ADDR: begin
                    r_crc  <= w_crc_next;
                    r_addr <= {r_addr[2:0], bus.bus_in};
                end
                S_DATA: begin
                    r_crc   <= w_crc_next;
                    r_shift <= {r_shift[62:0], bus.bus_in};
                end
                S_CRC:  r_crc_rx <= {r_crc_rx[1:0], bus.bus_in};
                default: ;
            endcase

            // Frames for other nodes run to completion but leave no trace
            if (w_frame_end && w_addr_match) begin
                if (w_crc_ok) begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= r_shift;
                    if (r_frame_cnt != 8'hFF) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end else begin
                    r_crc_err <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.crc_err   = r_crc_err;
    assign bus.busy      = w_busy;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_bus_receiver.sv
// Directed bench for bus_receiver: valid, bad-CRC, foreign, back-to-back, aborted and saturating frames.
module tb_bus_receiver;

    logic clock;
    logic reset_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int   valid_pulses = 0;
    int   err_pulses = 0;
    int   both_high = 0;
    int   busy_cycles = 0;
    int   prev_valid_cyc = 0;
    int   last_valid_cyc = 0;

    bus_receiver_if bus();

    bus_receiver #(.MY_ADDR(4'd1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse and busy monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.rx_valid === 1'b1) begin
            valid_pulses   <= valid_pulses + 1;
            prev_valid_cyc <= last_valid_cyc;
            last_valid_cyc <= cyc;
        end
        if (bus.crc_err === 1'b1) err_pulses <= err_pulses + 1;
        if (bus.rx_valid === 1'b1 && bus.crc_err === 1'b1) both_high <= both_high + 1;
        if (bus.busy === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference CRC by polynomial long division of {addr,data}*x^4 mod x^4+x+1
    function automatic logic [3:0] crc_model(input logic [3:0] a, input logic [63:0] d);
        logic [71:0] m;
        m = {a, d, 4'h0};
        for (int i = 71; i >= 4; i--) begin
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        end
        return m[3:0];
    endfunction

    task automatic send_frame(input logic [3:0] a, input logic [63:0] d, input logic [3:0] c,
                              input bit verbose, output int start_cyc);
        logic [72:0] f;
        f = {1'b1, a, d, c};
        start_cyc = 0;
        for (int i = 72; i >= 0; i--) begin
            bus.bus_in = f[i];
            tick();
            if (i == 72) start_cyc = cyc;
        end
        bus.bus_in = 1'b0;
        if (verbose)
            $display("frame addr=%h data=%h crc=%h start_cyc=%0d rx_valid=%b crc_err=%b frame_cnt=%0d err_cnt=%0d",
                     a, d, c, start_cyc, bus.rx_valid, bus.crc_err, bus.frame_cnt, bus.err_cnt);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        bus.bus_in = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.bus_in = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.rx_data !== 64'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 0", bus.rx_data); end
        n_checks++;
        if (bus.rx_valid !== 1'b0 || bus.crc_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b err=%b busy=%b expected 0/0/0", bus.rx_valid, bus.crc_err, bus.busy);
        end
        n_checks++;
        if (bus.frame_cnt !== 8'h00 || bus.err_cnt !== 8'h00) begin
            n_fail++; $display("FAIL reset_counters: got %h/%h expected 00/00", bus.frame_cnt, bus.err_cnt);
        end
        reset_n = 1'b1;
        tick();
        $display("reset done at cyc=%0d", cyc);
    endtask

    task automatic test_valid_frame();
        int st, vp0, bc0;
        vp0 = valid_pulses;
        bc0 = busy_cycles;
        send_frame(4'h1, 64'h1, 4'h6, 1'b1, st);
        n_checks++;
        if (bus.rx_valid !== 1'b1 || bus.crc_err !== 1'b0) begin
            n_fail++; $display("FAIL valid_pulse: got valid=%b err=%b expected 1/0", bus.rx_valid, bus.crc_err);
        end
        n_checks++;
        if (bus.rx_data !== 64'h1) begin n_fail++; $display("FAIL valid_rx_data: got %h expected 1", bus.rx_data); end
        n_checks++;
        if (bus.frame_cnt !== 8'd1 || bus.err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL valid_counters: got %0d/%0d expected 1/0", bus.frame_cnt, bus.err_cnt);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL valid_idle_on_pulse: busy got %b expected 0", bus.busy); end
        tick();
        n_checks++;
        if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b expected 0", bus.rx_valid); end
        n_checks++;
        if (valid_pulses - vp0 != 1) begin n_fail++; $display("FAIL valid_pulse_count: got %0d expected 1", valid_pulses - vp0); end
        n_checks++;
        if (last_valid_cyc - st != 72) begin n_fail++; $display("FAIL valid_latency: got %0d expected 72", last_valid_cyc - st); end
        n_checks++;
        if (busy_cycles - bc0 != 72) begin n_fail++; $display("FAIL valid_busy_len: got %0d expected 72", busy_cycles - bc0); end
    endtask

    task automatic test_crc_error();
        int st, vp0, ep0;
        vp0 = valid_pulses;
        ep0 = err_pulses;
        send_frame(4'h1, 64'h1, 4'h7, 1'b1, st);
        n_checks++;
        if (bus.crc_err !== 1'b1 || bus.rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL crcerr_pulse: got err=%b valid=%b expected 1/0", bus.crc_err, bus.rx_valid);
        end
        n_checks++;
        if (bus.err_cnt !== 8'd1 || bus.frame_cnt !== 8'd1) begin
            n_fail++; $display("FAIL crcerr_counters: got frame=%0d err=%0d expected 1/1", bus.frame_cnt, bus.err_cnt);
        end
        n_checks++;
        if (bus.rx_data !== 64'h1) begin n_fail++; $display("FAIL crcerr_rx_data: got %h expected 1", bus.rx_data); end
        tick();
        n_checks++;
        if (bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL crcerr_one_cycle: got %b expected 0", bus.crc_err); end
        n_checks++;
        if (err_pulses - ep0 != 1 || valid_pulses != vp0) begin
            n_fail++; $display("FAIL crcerr_pulse_count: got err=%0d valid=%0d expected 1/0", err_pulses - ep0, valid_pulses - vp0);
        end
    endtask

    task automatic test_data_pattern();
        int st;
        logic [63:0] d;
        d = 64'hA5C3_0123_4567_89AB;
        send_frame(4'h1, d, crc_model(4'h1, d), 1'b1, st);
        n_checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== d) begin
            n_fail++; $display("FAIL pattern_rx: got valid=%b data=%h expected 1 %h", bus.rx_valid, bus.rx_data, d);
        end
        n_checks++;
        if (bus.frame_cnt !== 8'd2) begin n_fail++; $display("FAIL pattern_frame_cnt: got %0d expected 2", bus.frame_cnt); end
        tick();
    endtask

    task automatic test_other_addr();
        int st, vp0, ep0, bc0;
        vp0 = valid_pulses;
        ep0 = err_pulses;
        bc0 = busy_cycles;
        send_frame(4'h2, 64'h1, 4'h6, 1'b1, st);
        tick();
        n_checks++;
        if (valid_pulses != vp0 || err_pulses != ep0) begin
            n_fail++; $display("FAIL other_no_pulse: got valid=%0d err=%0d expected 0/0", valid_pulses - vp0, err_pulses - ep0);
        end
        n_checks++;
        if (bus.frame_cnt !== 8'd2 || bus.err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL other_counters: got %0d/%0d expected 2/1", bus.frame_cnt, bus.err_cnt);
        end
        n_checks++;
        if (bus.rx_data !== 64'hA5C3_0123_4567_89AB) begin
            n_fail++; $display("FAIL other_rx_data: got %h expected a5c3012345678 9ab", bus.rx_data);
        end
        n_checks++;
        if (busy_cycles - bc0 != 72 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL other_busy: got %0d cycles busy=%b expected 72/0", busy_cycles - bc0, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int st1, st2, vp0;
        do_reset();
        vp0 = valid_pulses;
        send_frame(4'h1, 64'h1, 4'h6, 1'b1, st1);
        send_frame(4'h1, 64'h1, 4'h6, 1'b1, st2);
        tick();
        n_checks++;
        if (valid_pulses - vp0 != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", valid_pulses - vp0); end
        n_checks++;
        if (last_valid_cyc - prev_valid_cyc != 73) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d expected 73", last_valid_cyc - prev_valid_cyc);
        end
        n_checks++;
        if (bus.frame_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_frame_cnt: got %0d expected 2", bus.frame_cnt); end
    endtask

    task automatic test_reset_abort();
        int st, vp0, ep0;
        logic [72:0] f;
        do_reset();
        vp0 = valid_pulses;
        ep0 = err_pulses;
        f = {1'b1, 4'h1, 64'h1, 4'h6};
        for (int i = 72; i > 42; i--) begin
            bus.bus_in = f[i];
            tick();
        end
        reset_n    = 1'b0;
        bus.bus_in = 1'b0;
        tick();
        reset_n = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        for (int i = 0; i < 3; i++) tick();
        send_frame(4'h1, 64'h1, 4'h6, 1'b1, st);
        tick();
        n_checks++;
        if (valid_pulses - vp0 != 1 || err_pulses != ep0) begin
            n_fail++; $display("FAIL abort_pulses: got valid=%0d err=%0d expected 1/0", valid_pulses - vp0, err_pulses - ep0);
        end
        n_checks++;
        if (bus.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_frame_cnt: got %0d expected 1", bus.frame_cnt); end
    endtask

    task automatic test_saturation();
        int st;
        do_reset();
        for (int k = 0; k < 255; k++) send_frame(4'h1, 64'h1, 4'h6, 1'b0, st);
        tick();
        $display("saturation: 255 frames sent frame_cnt=%h", bus.frame_cnt);
        n_checks++;
        if (bus.frame_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_255: got %h expected ff", bus.frame_cnt); end
        send_frame(4'h1, 64'h1, 4'h6, 1'b1, st);
        tick();
        n_checks++;
        if (bus.frame_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_256: got %h expected ff", bus.frame_cnt); end
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.bus_in = 1'b0;
        test_reset();
        test_valid_frame();
        test_crc_error();
        test_data_pattern();
        test_other_addr();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        n_checks++;
        if (both_high != 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d overlaps expected 0", both_high); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
